// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: 1-cycle latency, no input-to-output combinational path.
// stall_in holds all contents; flush_in (dominant over stall) loads a zeroed bubble.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        alu_op_in,
  input  logic              alu_src_in,
  input  logic [DATA_W-1:0] read_data_1_in,
  input  logic [DATA_W-1:0] read_data_2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [9:0]        funct_in,
  input  logic [REG_AW-1:0] rs1_addr_in,
  input  logic [REG_AW-1:0] rs2_addr_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  output logic              valid_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [1:0]        alu_op_out,
  output logic              alu_src_out,
  output logic [DATA_W-1:0] read_data_1_out,
  output logic [DATA_W-1:0] read_data_2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [9:0]        funct_out,
  output logic [REG_AW-1:0] rs1_addr_out,
  output logic [REG_AW-1:0] rs2_addr_out,
  output logic [REG_AW-1:0] rd_addr_out,
  output logic [CNT_W-1:0]  bubble_cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic bubble_taken;
  logic cnt_inc;

  // A bubble is either a flush or a load of an empty ID slot; stalls never count.
  assign bubble_taken = flush_in || (!stall_in && !valid_in);
  assign cnt_inc      = bubble_taken && (bubble_cnt_out != CNT_MAX);

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      valid_out       <= 1'b0;
      reg_write_out   <= 1'b0;
      mem_to_reg_out  <= 1'b0;
      mem_read_out    <= 1'b0;
      mem_write_out   <= 1'b0;
      alu_op_out      <= 2'b00;
      alu_src_out     <= 1'b0;
      read_data_1_out <= '0;
      read_data_2_out <= '0;
      imm_out         <= '0;
      funct_out       <= '0;
      rs1_addr_out    <= '0;
      rs2_addr_out    <= '0;
      rd_addr_out     <= '0;
    end else if (!stall_in) begin
      // An invalid slot keeps its data but must never write registers or memory.
      valid_out       <= valid_in;
      reg_write_out   <= valid_in & reg_write_in;
      mem_to_reg_out  <= valid_in & mem_to_reg_in;
      mem_read_out    <= valid_in & mem_read_in;
      mem_write_out   <= valid_in & mem_write_in;
      alu_op_out      <= valid_in ? alu_op_in : 2'b00;
      alu_src_out     <= valid_in & alu_src_in;
      read_data_1_out <= read_data_1_in;
      read_data_2_out <= read_data_2_in;
      imm_out         <= imm_in;
      funct_out       <= funct_in;
      rs1_addr_out    <= rs1_addr_in;
      rs2_addr_out    <= rs2_addr_in;
      rd_addr_out     <= rd_addr_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bubble_cnt_out <= '0;
    end else if (cnt_inc) begin
      bubble_cnt_out <= bubble_cnt_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomised and directed bench for id_ex_pipe_reg; a 16-bit and a 4-bit counter
// instance share stimulus and are checked against a slot/counter model every cycle.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, stall_in, flush_in, valid_in;
  logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in, alu_src_in;
  logic [1:0]  alu_op_in;
  logic [31:0] read_data_1_in, read_data_2_in, imm_in;
  logic [9:0]  funct_in;
  logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in;

  logic        valid_out, reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out, alu_src_out;
  logic [1:0]  alu_op_out;
  logic [31:0] read_data_1_out, read_data_2_out, imm_out;
  logic [9:0]  funct_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic [15:0] bubble_cnt_out;

  logic        s_valid, s_rw, s_m2r, s_mr, s_mw, s_src;
  logic [1:0]  s_op;
  logic [31:0] s_rd1, s_rd2, s_imm;
  logic [9:0]  s_funct;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_cnt;

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .alu_op_in(alu_op_in),
    .alu_src_in(alu_src_in), .read_data_1_in(read_data_1_in), .read_data_2_in(read_data_2_in),
    .imm_in(imm_in), .funct_in(funct_in), .rs1_addr_in(rs1_addr_in),
    .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .valid_out(valid_out), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .alu_op_out(alu_op_out),
    .alu_src_out(alu_src_out), .read_data_1_out(read_data_1_out),
    .read_data_2_out(read_data_2_out), .imm_out(imm_out), .funct_out(funct_out),
    .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out), .rd_addr_out(rd_addr_out),
    .bubble_cnt_out(bubble_cnt_out)
  );

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut_small (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .alu_op_in(alu_op_in),
    .alu_src_in(alu_src_in), .read_data_1_in(read_data_1_in), .read_data_2_in(read_data_2_in),
    .imm_in(imm_in), .funct_in(funct_in), .rs1_addr_in(rs1_addr_in),
    .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .valid_out(s_valid), .reg_write_out(s_rw), .mem_to_reg_out(s_m2r),
    .mem_read_out(s_mr), .mem_write_out(s_mw), .alu_op_out(s_op),
    .alu_src_out(s_src), .read_data_1_out(s_rd1), .read_data_2_out(s_rd2),
    .imm_out(s_imm), .funct_out(s_funct), .rs1_addr_out(s_rs1), .rs2_addr_out(s_rs2),
    .rd_addr_out(s_rd), .bubble_cnt_out(s_cnt)
  );

  slot_t dut_slot, small_slot;
  assign dut_slot = '{valid_out, reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out,
                      alu_op_out, alu_src_out, read_data_1_out, read_data_2_out, imm_out,
                      funct_out, rs1_addr_out, rs2_addr_out, rd_addr_out};
  assign small_slot = '{s_valid, s_rw, s_m2r, s_mr, s_mw, s_op, s_src, s_rd1, s_rd2, s_imm,
                        s_funct, s_rs1, s_rs2, s_rd};

  // Reference model: the slot EX sees and how many bubbles have been issued.
  slot_t exp_slot;
  int    exp_cnt, exp_cnt4;
  int    tests = 0;
  int    fails = 0;

  function automatic slot_t input_slot();
    slot_t s;
    s = '{valid_in, reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in, alu_op_in,
          alu_src_in, read_data_1_in, read_data_2_in, imm_in, funct_in, rs1_addr_in,
          rs2_addr_in, rd_addr_in};
    if (!valid_in) begin
      s.reg_write = 0; s.mem_to_reg = 0; s.mem_read = 0; s.mem_write = 0;
      s.alu_op = 0; s.alu_src = 0;
    end
    return s;
  endfunction

  task automatic model_edge();
    if (!rst_in) begin
      exp_slot = '0; exp_cnt = 0; exp_cnt4 = 0;
    end else if (flush_in || !stall_in) begin
      if (flush_in) exp_slot = '0;
      else exp_slot = input_slot();
      if (flush_in || !valid_in) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt4 < 15) exp_cnt4++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_model();
    tests++;
    if (dut_slot !== exp_slot) begin
      fails++;
      $display("FAIL slot16: got %h, expected %h at %0t", dut_slot, exp_slot, $time);
    end
    tests++;
    if (small_slot !== exp_slot) begin
      fails++;
      $display("FAIL slot4: got %h, expected %h at %0t", small_slot, exp_slot, $time);
    end
    chk("cnt16", {16'h0, bubble_cnt_out}, exp_cnt);
    chk("cnt4", {28'h0, s_cnt}, exp_cnt4);
  endtask

  task automatic rand_inputs();
    rst_in         = ($urandom_range(0, 31) != 0);
    flush_in       = ($urandom_range(0, 7) == 0);
    stall_in       = ($urandom_range(0, 3) == 0);
    valid_in       = ($urandom_range(0, 3) != 0);
    reg_write_in   = $urandom_range(0, 1);
    mem_to_reg_in  = $urandom_range(0, 1);
    mem_read_in    = $urandom_range(0, 1);
    mem_write_in   = $urandom_range(0, 1);
    alu_src_in     = $urandom_range(0, 1);
    alu_op_in      = 2'($urandom_range(0, 3));
    read_data_1_in = $urandom;
    read_data_2_in = $urandom;
    imm_in         = $urandom;
    funct_in       = 10'($urandom);
    rs1_addr_in    = 5'($urandom);
    rs2_addr_in    = 5'($urandom);
    rd_addr_in     = 5'($urandom);
  endtask

  task automatic quiet_load();
    rand_inputs();
    rst_in = 1; flush_in = 0; stall_in = 0; valid_in = 1;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    exp_slot = '0; exp_cnt = 0; exp_cnt4 = 0;
    rand_inputs();
    #2;

    // Reset with every input high
    {stall_in, flush_in, valid_in, reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in,
     alu_src_in} = '1;
    alu_op_in = '1; read_data_1_in = '1; read_data_2_in = '1; imm_in = '1; funct_in = '1;
    rs1_addr_in = '1; rs2_addr_in = '1; rd_addr_in = '1;
    rst_in = 0;
    tick();
    chk("rst_valid", {31'h0, valid_out}, 0);
    chk("rst_rd1", read_data_1_out, 0);
    chk("rst_cnt", {16'h0, bubble_cnt_out}, 0);

    // Plain load
    quiet_load();
    read_data_1_in = 32'h0000_0005; imm_in = 32'hFFFF_FFFC; rd_addr_in = 5'd7; reg_write_in = 1;
    tick();
    chk("ld_valid", {31'h0, valid_out}, 1);
    chk("ld_rw", {31'h0, reg_write_out}, 1);
    chk("ld_rd1", read_data_1_out, 32'h0000_0005);
    chk("ld_imm", imm_out, 32'hFFFF_FFFC);
    chk("ld_rd", {27'h0, rd_addr_out}, 7);

    // Stall for 3 edges with new data presented
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      rst_in = 1; flush_in = 0; stall_in = 1;
      read_data_1_in = 32'hDEAD_BEEF; read_data_2_in = 32'hDEAD_BEEF; imm_in = 32'hDEAD_BEEF;
      tick();
    end
    chk("st_rd1", read_data_1_out, 32'h0000_0005);
    chk("st_imm", imm_out, 32'hFFFF_FFFC);
    chk("st_rd", {27'h0, rd_addr_out}, 7);
    chk("st_cnt", {16'h0, bubble_cnt_out}, 0);

    // Flush and stall on the same edge
    quiet_load();
    flush_in = 1; stall_in = 1; mem_write_in = 1;
    tick();
    chk("fl_valid", {31'h0, valid_out}, 0);
    chk("fl_mw", {31'h0, mem_write_out}, 0);
    chk("fl_imm", imm_out, 0);
    chk("fl_cnt", {16'h0, bubble_cnt_out}, 1);

    // Reset mid-stream, then a normal load
    for (int i = 0; i < 3; i++) begin
      quiet_load();
      tick();
    end
    quiet_load();
    rst_in = 0;
    tick();
    chk("mr_valid", {31'h0, valid_out}, 0);
    chk("mr_rd1", read_data_1_out, 0);
    chk("mr_cnt", {16'h0, bubble_cnt_out}, 0);
    quiet_load();
    read_data_1_in = 32'h0000_1234;
    tick();
    chk("pr_valid", {31'h0, valid_out}, 1);
    chk("pr_rd1", read_data_1_out, 32'h0000_1234);

    // Invalid slot: data loads, control zeroed, counted as a bubble
    quiet_load();
    valid_in = 0; mem_write_in = 1; read_data_2_in = 32'h0000_00AB;
    tick();
    chk("inv_mw", {31'h0, mem_write_out}, 0);
    chk("inv_rd2", read_data_2_out, 32'h0000_00AB);
    chk("inv_cnt", {16'h0, bubble_cnt_out}, 1);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      quiet_load();
      flush_in = 1;
      tick();
    end
    chk("sat_cnt4", {28'h0, s_cnt}, 15);
    chk("sat_cnt16", {16'h0, bubble_cnt_out}, 21);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
